// File: rtl/execute_stage.sv
// Execute stage: ALU, operand forwarding, load-use / RAW hazard detection and
// the EX/MEM pipeline register, including the registered JALR redirect.
// Build option: define EX_FWD_EN to enable EX/MEM -> EX forwarding. Without it,
// any dependency on the instruction in EX/MEM costs one bubble.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [4:0]  ctl,
    input  logic [31:0] imm,
    input  logic [31:0] jalr_imm,
    input  logic        src_imm,
    input  logic        src_pc,
    input  logic        is_jalr,
    input  logic        read_reg1,
    input  logic        read_reg2,
    input  logic [4:0]  reg1_addr,
    input  logic [4:0]  reg2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  write_reg,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] pc_in,
    output logic [31:0] result,
    output logic [31:0] store_data,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        hazard_stall
);

    typedef enum logic [4:0] {
        OpAnd   = 5'd0,
        OpOr    = 5'd1,
        OpAdd   = 5'd2,
        OpXor   = 5'd3,
        OpSll   = 5'd4,
        OpSrl   = 5'd5,
        OpSub   = 5'd6,
        OpSlt   = 5'd7,
        OpPassB = 5'd10,
        OpSltu  = 5'd13,
        OpSra   = 5'd15,
        OpZero  = 5'd31
    } alu_op_e;

    // EX/MEM pipeline register
    logic [31:0] result_q, result_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic [31:0] jalr_target;
    logic        dep_rs1;
    logic        dep_rs2;
    logic        dep_any;
    logic        hazard;

`ifdef EX_FWD_EN
    logic        fwd_ok;

    // Bypass the EX/MEM ALU result; load data is not available yet, x0 is never bypassed
    always_comb begin
        fwd_ok  = reg_write_q && !mem_read_q && (rd_q != 5'd0);
        fwd_rs1 = (fwd_ok && (rd_q == reg1_addr)) ? result_q : rs1_data;
        fwd_rs2 = (fwd_ok && (rd_q == reg2_addr)) ? result_q : rs2_data;
    end
`else
    // No bypass network: dependencies are resolved by bubbling instead
    always_comb begin
        fwd_rs1 = rs1_data;
        fwd_rs2 = rs2_data;
    end
`endif

    // Dependency of the instruction in EX on the one held in EX/MEM
    always_comb begin
        dep_rs1 = read_reg1 && (reg1_addr == rd_q);
        dep_rs2 = read_reg2 && (reg2_addr == rd_q);
        dep_any = (rd_q != 5'd0) && (dep_rs1 || dep_rs2);
`ifdef EX_FWD_EN
        hazard  = mem_read_q && dep_any;
`else
        hazard  = reg_write_q && dep_any;
`endif
    end

    // Operand selection and ALU
    always_comb begin
        op_a    = src_pc ? pc_in : fwd_rs1;
        op_b    = src_imm ? imm : fwd_rs2;
        shamt   = op_b[4:0];
        alu_res = 32'd0;
        case (alu_op_e'(ctl))
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpAdd:   alu_res = op_a + op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpSll:   alu_res = op_a << shamt;
            OpSrl:   alu_res = op_a >> shamt;
            OpSub:   alu_res = op_a - op_b;
            OpSlt:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OpSltu:  alu_res = {31'd0, op_a < op_b};
            OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OpPassB: alu_res = op_b;
            OpZero:  alu_res = 32'd0;
            default: alu_res = 32'd0;
        endcase
    end

    // JALR writes the link address and computes the target from the forwarded rs1
    always_comb begin
        ex_result   = is_jalr ? (pc_in + 32'd4) : alu_res;
        jalr_target = (fwd_rs1 + jalr_imm) & ~32'd1;
    end

    // Next state: reset beats stall, stall freezes, hazard inserts a bubble
    always_comb begin
        result_d      = result_q;
        store_data_d  = store_data_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        if (rst) begin
            result_d      = 32'd0;
            store_data_d  = 32'd0;
            rd_d          = 5'd0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            redirect_d    = 1'b0;
            redirect_pc_d = 32'd0;
        end else if (!stall) begin
            if (hazard) begin
                result_d     = 32'd0;
                store_data_d = 32'd0;
                rd_d         = 5'd0;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                redirect_d   = 1'b0;
            end else begin
                result_d     = ex_result;
                store_data_d = fwd_rs2;
                rd_d         = write_reg;
                reg_write_d  = reg_write;
                mem_read_d   = mem_read;
                mem_write_d  = mem_write;
                redirect_d   = is_jalr;
                if (is_jalr) begin
                    redirect_pc_d = jalr_target;
                end
            end
        end
    end

    // EX/MEM state register; reset is applied synchronously through the _d logic
    always_ff @(posedge clk) begin
        result_q      <= result_d;
        store_data_q  <= store_data_d;
        rd_q          <= rd_d;
        reg_write_q   <= reg_write_d;
        mem_read_q    <= mem_read_d;
        mem_write_q   <= mem_write_d;
        redirect_q    <= redirect_d;
        redirect_pc_q <= redirect_pc_d;
    end

    // Drive outputs from the registered state
    always_comb begin
        result        = result_q;
        store_data    = store_data_q;
        rd_out        = rd_q;
        reg_write_out = reg_write_q;
        mem_read_out  = mem_read_q;
        mem_write_out = mem_write_q;
        redirect      = redirect_q;
        redirect_pc   = redirect_pc_q;
        hazard_stall  = hazard;
    end

endmodule
